// File: rtl/kernel_normalizer.sv
// kernel_normalizer: scales a raw KxK kernel so its coefficients sum to ~2^FRAC_W.
// Ports: clk, n_rst (async, active-low); start/kernel_size/round_en/raw_kernel
//        request inputs; kernel result array; busy, done pulse, err status.
module kernel_normalizer #(
    parameter int MAX_KERNEL = 5,
    parameter int IN_W       = 8,
    parameter int OUT_W      = 8,
    parameter int FRAC_W     = 8,
    localparam int SZ_W      = $clog2(MAX_KERNEL + 1),
    localparam int SUM_W     = IN_W + $clog2(MAX_KERNEL * MAX_KERNEL + 1),
    localparam int Q_W       = IN_W + FRAC_W
) (
    input  logic                                             clk,
    input  logic                                             n_rst,
    input  logic                                             start,
    input  logic [SZ_W-1:0]                                  kernel_size,
    input  logic                                             round_en,
    input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][IN_W-1:0]  raw_kernel,
    output logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][OUT_W-1:0] kernel,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             err
);

    localparam int DVD_W = Q_W + 1;
    localparam int IDX_W = $clog2(DVD_W);
    localparam int BIT_W = $clog2(Q_W);
    localparam logic [Q_W-1:0] SAT = Q_W'({OUT_W{1'b1}});

    typedef logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][IN_W-1:0]  raw_arr_t;
    typedef logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][OUT_W-1:0] out_arr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUM,
        S_DIV
    } state_t;

    state_t             state_q, state_d;
    raw_arr_t           raw_q, raw_d;
    logic [SZ_W-1:0]    k_q, k_d;
    logic               rnd_q, rnd_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [SZ_W-1:0]    row_q, row_d;
    logic [SZ_W-1:0]    col_q, col_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [SUM_W-1:0]   rem_q, rem_d;
    logic [Q_W-2:0]     quo_q, quo_d;
    out_arr_t           work_q, work_d;
    out_arr_t           kernel_q, kernel_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [IN_W-1:0]    elem;
    logic [SUM_W-1:0]   sum_nx;
    logic [DVD_W-1:0]   dividend;
    logic [IDX_W-1:0]   nbit;
    logic               first;
    logic [SUM_W-1:0]   rem_in;
    logic [SUM_W:0]     trial;
    logic               qbit;
    logic [SUM_W-1:0]   rem_nx;
    logic [Q_W-1:0]     quo_nx;
    logic [OUT_W-1:0]   coeff;
    logic [SZ_W-1:0]    k_last;
    logic               last_col;
    logic               last_elem;
    logic               last_bit;
    logic               size_ok;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            raw_q    <= '0;
            k_q      <= '0;
            rnd_q    <= 1'b0;
            sum_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            bit_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            work_q   <= '0;
            kernel_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            raw_q    <= raw_d;
            k_q      <= k_d;
            rnd_q    <= rnd_d;
            sum_q    <= sum_d;
            row_q    <= row_d;
            col_q    <= col_d;
            bit_q    <= bit_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            work_q   <= work_d;
            kernel_q <= kernel_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Element datapath shared by SUM and DIV.
    always_comb begin
        elem      = raw_q[row_q][col_q];
        sum_nx    = sum_q + SUM_W'(elem);
        dividend  = (DVD_W'(elem) << FRAC_W)
                  + (rnd_q ? DVD_W'(sum_q >> 1) : '0);
        nbit      = IDX_W'(Q_W - 1) - IDX_W'(bit_q);
        first     = (bit_q == '0);
        // Dividend top bit never yields a quotient bit (result <= 2^FRAC_W),
        // so it preloads the remainder and Q_W steps cover the rest.
        rem_in    = first ? SUM_W'(dividend[Q_W]) : rem_q;
        trial     = {rem_in, dividend[nbit]};
        qbit      = (trial >= {1'b0, sum_q});
        rem_nx    = qbit ? SUM_W'(trial - {1'b0, sum_q}) : SUM_W'(trial);
        quo_nx    = first ? Q_W'(qbit) : {quo_q, qbit};
        coeff     = (quo_nx > SAT) ? OUT_W'(SAT) : OUT_W'(quo_nx);
        k_last    = k_q - SZ_W'(1);
        last_col  = (col_q == k_last);
        last_elem = last_col && (row_q == k_last);
        last_bit  = (bit_q == BIT_W'(Q_W - 1));
        size_ok   = kernel_size[0] && (kernel_size <= SZ_W'(MAX_KERNEL));
    end

    always_comb begin
        state_d  = state_q;
        raw_d    = raw_q;
        k_d      = k_q;
        rnd_d    = rnd_q;
        sum_d    = sum_q;
        row_d    = row_q;
        col_d    = col_q;
        bit_d    = bit_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        work_d   = work_q;
        kernel_d = kernel_q;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                // done_q blocks acceptance in the completion cycle.
                if (start && !done_q) begin
                    if (size_ok) begin
                        raw_d   = raw_kernel;
                        k_d     = kernel_size;
                        rnd_d   = round_en;
                        sum_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                        bit_d   = '0;
                        work_d  = '0;
                        err_d   = 1'b0;
                        state_d = S_SUM;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end

            S_SUM: begin
                sum_d = sum_nx;
                if (last_elem) begin
                    row_d = '0;
                    col_d = '0;
                    bit_d = '0;
                    if (sum_nx == '0) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DIV;
                    end
                end else if (last_col) begin
                    col_d = '0;
                    row_d = row_q + SZ_W'(1);
                end else begin
                    col_d = col_q + SZ_W'(1);
                end
            end

            S_DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx[Q_W-2:0];
                bit_d = bit_q + BIT_W'(1);
                if (last_bit) begin
                    bit_d = '0;
                    work_d[row_q][col_q] = coeff;
                    if (last_elem) begin
                        kernel_d = work_d;
                        done_d   = 1'b1;
                        err_d    = 1'b0;
                        state_d  = S_IDLE;
                    end else if (last_col) begin
                        col_d = '0;
                        row_d = row_q + SZ_W'(1);
                    end else begin
                        col_d = col_q + SZ_W'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign kernel = kernel_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign err    = err_q;

endmodule
